uart_encoder: RTL

Response-path serializer for the UART-to-Wishbone bridge: the transmit-side counterpart of `UartDecoder`. It accepts one 34-bit response word (2-bit type + 32-bit payload) on a strobe. It emits that word as an ASCII frame, one byte at a time, into the `UartTop` transmitter using the `in_data`/`in_valid`/`out_BUSY` handshake. It sits between the Wishbone master logic and `UartTop` in `wishbone_top`.

---
 rtl/uart_encoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/uart_encoder.sv
// Response-word serializer: emits {type char, 8 hex digits[, 8'h0A]} byte by byte into the UART TX.
// Optional trailing newline is enabled by defining UART_ENCODER_NEWLINE_EN.
module uart_encoder (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stb,
    input  logic [33:0] i_word,
    output logic        o_busy,
    output logic        o_drop,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_stb,
    input  logic        i_tx_busy
);

`ifdef UART_ENCODER_NEWLINE_EN
    localparam logic [3:0] LAST = 4'd9;
`else
    localparam logic [3:0] LAST = 4'd8;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [33:0] word_q, word_d;
    logic [7:0]  data_q, data_d;
    logic [3:0]  nibble;
    logic [7:0]  cur_byte;

    always_comb begin
        unique case (idx_q)
            4'd1:    nibble = word_q[31:28];
            4'd2:    nibble = word_q[27:24];
            4'd3:    nibble = word_q[23:20];
            4'd4:    nibble = word_q[19:16];
            4'd5:    nibble = word_q[15:12];
            4'd6:    nibble = word_q[11:8];
            4'd7:    nibble = word_q[7:4];
            4'd8:    nibble = word_q[3:0];
            default: nibble = 4'h0;
        endcase
    end

    // Index 0 is the type char, 1..8 the hex digits, anything above is the newline.
    always_comb begin
        if (idx_q == 4'd0) begin
            unique case (word_q[33:32])
                2'b00:   cur_byte = 8'h41;
                2'b01:   cur_byte = 8'h52;
                2'b10:   cur_byte = 8'h57;
                default: cur_byte = 8'h45;
            endcase
        end else if (idx_q <= 4'd8) begin
            cur_byte = (nibble < 4'd10) ? {4'h3, nibble} : (8'h37 + {4'h0, nibble});
        end else begin
            cur_byte = 8'h0A;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        word_d   = word_q;
        data_d   = data_q;
        o_tx_stb = 1'b0;
        o_busy   = (state_q != IDLE);
        o_drop   = i_stb && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (i_stb) begin
                    word_d  = i_word;
                    idx_d   = 4'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!i_tx_busy) begin
                    o_tx_stb = 1'b1;
                    data_d   = cur_byte;
                    state_d  = GUARD;
                end
            end
            // UART busy may only rise the cycle after the strobe, so skip looking at it once.
            GUARD: state_d = DRAIN;
            DRAIN: begin
                if (!i_tx_busy) begin
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        o_tx_data = o_tx_stb ? cur_byte : data_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            word_q  <= 34'd0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            data_q  <= data_d;
        end
    end

endmodule
